// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int          BCD_DIGITS      = 4;
    localparam int          BCD_MAX         = 9999;
    localparam logic [15:0] BCD_ERR_PATTERN = 16'hEEEE;
    localparam logic [15:0] BCD_SAT_PATTERN = 16'h9999;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of shift-and-add-3: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Build macro BCD_SATURATE_EN: out-of-range inputs show 9999 instead of EEEE.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_WIDTH-1:0] i_bin,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [15:0]          o_bcd,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int               CNT_W    = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

`ifdef BCD_SATURATE_EN
    localparam logic [15:0] RANGE_PATTERN = BCD_SAT_PATTERN;
`else
    localparam logic [15:0] RANGE_PATTERN = BCD_ERR_PATTERN;
`endif

    state_t               state;
    state_t               state_next;
    logic                 accept;
    logic                 finish;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_WIDTH-1:0] shreg;
    logic [15:0]          scratch;
    logic [15:0]          scratch_adj;
    logic [15:0]          scratch_shift;
    logic [15:0]          result;
    logic                 range_flag;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nibble   (scratch[4*g +: 4]),
            .adjusted (scratch_adj[4*g +: 4])
        );
    end

    // Digit-3 carry out only occurs for out-of-range values, which get replaced anyway.
    assign scratch_shift = (scratch_adj << 1) | 16'(shreg[BIN_WIDTH-1]);
    assign result        = range_flag ? RANGE_PATTERN : scratch_shift;
    assign o_ready       = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (cnt == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            shreg      <= '0;
            scratch    <= '0;
            range_flag <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            shreg      <= i_bin;
            scratch    <= '0;
            range_flag <= (32'(i_bin) > BCD_MAX);
        end else if (state == CONV) begin
            cnt        <= cnt + CNT_W'(1);
            shreg      <= shreg << 1;
            scratch    <= scratch_shift;
        end
    end

    // The final shift lands directly in o_bcd so the latency is exactly BIN_WIDTH clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_bcd  <= '0;
            o_err  <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= finish;
            if (finish) begin
                o_bcd <= result;
                o_err <= range_flag;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random sweeps on 14- and 8-bit builds.
module tb_bin_to_bcd_seq;

`ifdef BCD_SATURATE_EN
    localparam logic [15:0] OOR_PATTERN = 16'h9999;
`else
    localparam logic [15:0] OOR_PATTERN = 16'hEEEE;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] i_bin = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] o_bcd;
    logic        o_done;
    logic        o_err;

    logic [7:0]  i_bin8 = '0;
    logic        i_valid8 = 1'b0;
    logic        o_ready8;
    logic [15:0] o_bcd8;
    logic        o_done8;
    logic        o_err8;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_bcd = '0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_bcd8 = '0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_WIDTH(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_bin   (i_bin),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_bcd   (o_bcd),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_bin   (i_bin8),
        .i_valid (i_valid8),
        .o_ready (o_ready8),
        .o_bcd   (o_bcd8),
        .o_done  (o_done8),
        .o_err   (o_err8)
    );

    // Reference: decimal digits by plain division, pattern when above 9999.
    function automatic logic [15:0] modelBcd(input int v);
        if (v > 9999) return OOR_PATTERN;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [13:0] v);
        checkOutput("ready_before_accept", 32'(o_ready), 32'd1);
        i_bin   = v;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(o_ready), 32'd0);
        checkOutput("done_one_cycle", 32'(o_done), 32'd0);
    endtask

    // Waits for o_done; with jam set, keeps i_valid high and i_bin changing while busy.
    task automatic waitDone(input string tag, input int v, input bit jam);
        int cycles = 0;
        bit held_ok = 1'b1;
        while (!o_done && cycles < 40) begin
            if (jam) begin
                i_bin   = 14'($urandom_range(0, 16383));
                i_valid = 1'b1;
            end
            @(negedge clk);
            cycles++;
            if (!o_done && (o_bcd !== exp_bcd || o_err !== exp_err || o_ready !== 1'b0))
                held_ok = 1'b0;
        end
        i_valid = 1'b0;
        checkOutput({tag, "_held"}, 32'(held_ok), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd14);
        exp_bcd = modelBcd(v);
        exp_err = (v > 9999);
        checkOutput({tag, "_bcd"}, 32'(o_bcd), 32'(exp_bcd));
        checkOutput({tag, "_err"}, 32'(o_err), 32'(exp_err));
    endtask

    task automatic conv8(input int v);
        int cycles = 0;
        i_bin8   = 8'(v);
        i_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid8 = 1'b0;
        while (!o_done8 && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("w8_latency", 32'(cycles), 32'd8);
        exp_bcd8 = modelBcd(v);
        checkOutput("w8_bcd", 32'(o_bcd8), 32'(exp_bcd8));
        checkOutput("w8_err", 32'(o_err8), 32'd0);
        @(negedge clk);
        checkOutput("w8_done_drop", 32'(o_done8), 32'd0);
    endtask

    initial begin
        int v;
        int late;
        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_bcd", 32'(o_bcd), 32'h0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_err", 32'(o_err), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_bcd8", 32'(o_bcd8), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero input, fixed latency
        applyStimulus(14'd0);
        waitDone("zero", 0, 1'b0);

        // Back-to-back, second accept in the o_done cycle
        @(negedge clk);
        applyStimulus(14'd1234);
        waitDone("v1234", 1234, 1'b0);
        applyStimulus(14'd9999);
        waitDone("v9999", 9999, 1'b0);

        // Out of range
        @(negedge clk);
        applyStimulus(14'd10000);
        waitDone("v10000", 10000, 1'b0);
        @(negedge clk);
        applyStimulus(14'd16383);
        waitDone("v16383", 16383, 1'b0);

        // Busy input ignored
        @(negedge clk);
        applyStimulus(14'd567);
        waitDone("jam567", 567, 1'b1);
        @(negedge clk);
        checkOutput("jam_no_queue", 32'(o_ready), 32'd1);
        checkOutput("jam_done_drop", 32'(o_done), 32'd0);

        // Reset during conversion
        applyStimulus(14'd4321);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_bcd", 32'(o_bcd), 32'h0);
        checkOutput("abort_done", 32'(o_done), 32'd0);
        checkOutput("abort_ready", 32'(o_ready), 32'd1);
        checkOutput("abort_err", 32'(o_err), 32'd0);
        exp_bcd = '0;
        exp_err = 1'b0;
        exp_bcd8 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        late = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done || o_bcd !== 16'h0) late++;
        end
        checkOutput("abort_no_late_done", 32'(late), 32'd0);

        // Random sweep, 14-bit
        for (int k = 0; k < 30; k++) begin
            v = int'($urandom_range(0, 16383));
            applyStimulus(14'(v));
            waitDone("rand14", v, 1'b0);
            if (k % 3 == 0) repeat (int'($urandom_range(1, 4))) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        checkOutput("hold_bcd", 32'(o_bcd), 32'(exp_bcd));
        checkOutput("hold_err", 32'(o_err), 32'(exp_err));

        // Random sweep, 8-bit build including the boundaries
        conv8(255);
        conv8(0);
        for (int k = 0; k < 15; k++) conv8(int'($urandom_range(0, 255)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
